// File: rtl/debounce_pkg.sv
// Shared definitions for the debouncer: FSM state encodings and the counter-width helper.
// Latency: n/a (types, constants and an elaboration-time function only).
// Backpressure: n/a.
package debounce_pkg;

    // The encoding is chosen so that bit 1 is the settled level and bit0^bit1 marks a check state
    localparam logic [1:0] ST_STABLE_LO = 2'b00;
    localparam logic [1:0] ST_CHECK_HI  = 2'b01;
    localparam logic [1:0] ST_STABLE_HI = 2'b11;
    localparam logic [1:0] ST_CHECK_LO  = 2'b10;

    typedef enum logic [1:0] {
        STABLE_LO = ST_STABLE_LO,
        CHECK_HI  = ST_CHECK_HI,
        STABLE_HI = ST_STABLE_HI,
        CHECK_LO  = ST_CHECK_LO
    } state_t;

    // Ceiling log2, used to size the confirm counter so it can hold DEBOUNCE_CYCLES
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop shift chain bringing an asynchronous input into the clock domain.
// Latency: SYNC_STAGES clock edges from d to q.
// Backpressure: none, samples every edge.
module sync_chain
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clock,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Nothing may sit between the flops, so the next value is a pure shift
    assign sync_d = {sync_q[SYNC_STAGES-2:0], d};

    // Shift register; every stage comes out of reset at the assumed idle level
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/signal_debouncer.sv
// Debounces a raw asynchronous input into a clean level and counts rejected glitches.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from a raw level change to signal_clean.
// Backpressure: none; free-running sampler with no flow control.
module signal_debouncer
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter int   CNT_W           = clog2(DEBOUNCE_CYCLES + 1),
    parameter int   GLITCH_W        = 8,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                signal,
    output logic                signal_clean,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_count,
    input  logic                glitch_clr
);

    // With a single confirming sample there is nothing to check: the level is simply retimed
    localparam bit             FILTER_EN   = (DEBOUNCE_CYCLES > 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam state_t         RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic                sync_out;
    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                clean_q;
    logic                busy_q;
    logic [GLITCH_W-1:0] glitch_q;
    logic [GLITCH_W-1:0] glitch_d;
    logic                glitch_evt;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clock (clock),
        .rst_n (rst_n),
        .d     (signal),
        .q     (sync_out)
    );

    // A glitch is a check state that sees the candidate level disappear before it is confirmed
    always_comb begin
        glitch_evt = 1'b0;
        if (FILTER_EN) begin
            case (state_q)
                CHECK_HI: glitch_evt = !sync_out;
                CHECK_LO: glitch_evt = sync_out;
                default:  glitch_evt = 1'b0;
            endcase
        end
    end

    // Confirm-count FSM; busy and signal_clean are registered alongside the state
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            clean_q <= RESET_LEVEL;
            busy_q  <= 1'b0;
        end else if (!FILTER_EN) begin
            state_q <= sync_out ? STABLE_HI : STABLE_LO;
            cnt_q   <= '0;
            clean_q <= sync_out;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                STABLE_LO: begin
                    if (sync_out) begin
                        state_q <= CHECK_HI;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sync_out) begin
                        state_q <= CHECK_LO;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                CHECK_HI: begin
                    if (!sync_out) begin
                        // Bounced back, including on the would-be confirming edge
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        clean_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                CHECK_LO: begin
                    if (sync_out) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        clean_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= RESET_STATE;
                    cnt_q   <= '0;
                    clean_q <= RESET_LEVEL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Clear beats a coincident glitch; the count sticks at all-ones
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (glitch_evt && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    // Glitch counter register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign signal_clean = clean_q;
    assign busy         = busy_q;
    assign glitch_count = glitch_q;

endmodule

// File: tb/tb_signal_debouncer.sv
module tb_signal_debouncer;

    logic       clock;
    logic       rst_n;
    logic       signal;
    logic       clr_m;
    logic       clr_s;

    logic       clean_m, busy_m;
    logic [7:0] gc_m;
    logic       clean_s, busy_s;
    logic [1:0] gc_s;
    logic       clean_d, busy_d;
    logic [7:0] gc_d;

    int cyc    = 0;
    int base   = 0;
    int n_vec  = 0;
    int n_fail = 0;
    string tname = "";

    typedef struct {
        int         which;
        int         cyc;
        logic       clean;
        logic       busy;
        logic [7:0] glitch;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    signal_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .GLITCH_W(8)) dut (
        .clock(clock), .rst_n(rst_n), .signal(signal), .signal_clean(clean_m),
        .busy(busy_m), .glitch_count(gc_m), .glitch_clr(clr_m));

    signal_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .GLITCH_W(2)) dut_sat (
        .clock(clock), .rst_n(rst_n), .signal(signal), .signal_clean(clean_s),
        .busy(busy_s), .glitch_count(gc_s), .glitch_clr(clr_s));

    signal_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .GLITCH_W(8)) dut_d1 (
        .clock(clock), .rst_n(rst_n), .signal(signal), .signal_clean(clean_d),
        .busy(busy_d), .glitch_count(gc_d), .glitch_clr(1'b0));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // which: 0 = main (D=4,W=8), 1 = saturating (W=2), 2 = pass-through (D=1)
    task automatic push(input int which, input int n, input logic c, input logic b, input int g);
        exp_t e;
        string wn;
        e.which  = which;
        e.cyc    = base + n;
        e.clean  = c;
        e.busy   = b;
        e.glitch = 8'(g);
        wn = (which == 0) ? "main" : ((which == 1) ? "sat" : "d1");
        exp_q.push_back(e);
        name_q.push_back($sformatf("%s.n%0d.%s", tname, n, wn));
    endtask

    task automatic do_reset(input logic lvl);
        signal = lvl;
        clr_m  = 1'b0;
        clr_s  = 1'b0;
        rst_n  = 1'b0;
        tick(2);
        rst_n  = 1'b1;
    endtask

    // Monitor: compares every expectation that falls due on this cycle
    exp_t       mon_e;
    string      mon_n;
    logic       act_c, act_b;
    logic [7:0] act_g;
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            case (mon_e.which)
                0:       begin act_c = clean_m; act_b = busy_m; act_g = gc_m; end
                1:       begin act_c = clean_s; act_b = busy_s; act_g = {6'd0, gc_s}; end
                default: begin act_c = clean_d; act_b = busy_d; act_g = gc_d; end
            endcase
            n_vec++;
            if (mon_e.cyc != cyc || act_c !== mon_e.clean || act_b !== mon_e.busy ||
                act_g !== mon_e.glitch) begin
                n_fail++;
                $display("FAIL %s: clean/busy/glitch got %b/%b/%0d, expected %b/%b/%0d (cycle %0d vs due %0d)",
                         mon_n, act_c, act_b, act_g, mon_e.clean, mon_e.busy, mon_e.glitch, cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        // 1: reset with input high, then release
        tname  = "t1_reset";
        signal = 1'b1;
        clr_m  = 1'b0;
        clr_s  = 1'b0;
        rst_n  = 1'b0;
        tick(3);
        base = cyc;
        push(0, 0, 1'b0, 1'b0, 0);
        push(1, 0, 1'b0, 1'b0, 0);
        push(2, 0, 1'b0, 1'b0, 0);
        tick(1);
        base  = cyc;
        rst_n = 1'b1;
        push(0, 2, 1'b0, 1'b0, 0);
        push(2, 2, 1'b0, 1'b0, 0);
        push(0, 3, 1'b0, 1'b1, 0);
        push(2, 3, 1'b1, 1'b0, 0);
        push(0, 5, 1'b0, 1'b1, 0);
        push(0, 6, 1'b1, 1'b0, 0);
        push(1, 6, 1'b1, 1'b0, 0);
        tick(9);

        // 2: clean rising step, then clean falling step
        tname = "t2_step";
        do_reset(1'b0);
        tick(3);
        base = cyc;
        push(0, 0, 1'b0, 1'b0, 0);
        signal = 1'b1;
        push(0, 2, 1'b0, 1'b0, 0);
        push(2, 2, 1'b0, 1'b0, 0);
        push(0, 3, 1'b0, 1'b1, 0);
        push(2, 3, 1'b1, 1'b0, 0);
        push(0, 5, 1'b0, 1'b1, 0);
        push(0, 6, 1'b1, 1'b0, 0);
        push(0, 8, 1'b1, 1'b0, 0);
        tick(10);
        base   = cyc;
        signal = 1'b0;
        push(0, 2, 1'b1, 1'b0, 0);
        push(0, 3, 1'b1, 1'b1, 0);
        push(2, 3, 1'b0, 1'b0, 0);
        push(0, 5, 1'b1, 1'b1, 0);
        push(0, 6, 1'b0, 1'b0, 0);
        tick(10);

        // 3: three one-cycle pulses, then a steady high
        tname = "t3_bounce";
        do_reset(1'b0);
        tick(3);
        base = cyc;
        push(0, 3, 1'b0, 1'b1, 0);
        push(2, 3, 1'b1, 1'b0, 0);
        push(0, 4, 1'b0, 1'b0, 1);
        push(2, 4, 1'b0, 1'b0, 0);
        push(0, 6, 1'b0, 1'b0, 2);
        push(0, 8, 1'b0, 1'b0, 3);
        push(0, 9, 1'b0, 1'b1, 3);
        push(0, 11, 1'b0, 1'b1, 3);
        push(0, 12, 1'b1, 1'b0, 3);
        push(2, 12, 1'b1, 1'b0, 0);
        for (int t = 0; t < 14; t++) begin
            signal = (t >= 6) || (t % 2 == 0);
            tick(1);
        end
        tick(2);

        // 4: input drops on the last confirming sample
        tname = "t4_late";
        do_reset(1'b0);
        tick(3);
        base = cyc;
        push(0, 3, 1'b0, 1'b1, 0);
        push(0, 5, 1'b0, 1'b1, 0);
        push(0, 6, 1'b0, 1'b0, 1);
        push(1, 6, 1'b0, 1'b0, 1);
        push(0, 9, 1'b0, 1'b0, 1);
        for (int t = 0; t < 12; t++) begin
            signal = (t < 3);
            tick(1);
        end

        // 5: saturation at W=2, clear against a coincident glitch, plain clear
        tname = "t5_sat";
        do_reset(1'b0);
        tick(3);
        base = cyc;
        push(1, 4, 1'b0, 1'b0, 1);
        push(1, 8, 1'b0, 1'b0, 3);
        push(1, 10, 1'b0, 1'b0, 3);
        push(0, 12, 1'b0, 1'b0, 5);
        push(1, 12, 1'b0, 1'b0, 3);
        push(0, 13, 1'b0, 1'b1, 5);
        push(1, 13, 1'b0, 1'b1, 3);
        push(0, 14, 1'b0, 1'b0, 6);
        push(1, 14, 1'b0, 1'b0, 0);
        push(0, 15, 1'b0, 1'b0, 6);
        push(0, 16, 1'b0, 1'b0, 0);
        for (int t = 0; t < 18; t++) begin
            signal = (t <= 10) && (t % 2 == 0);
            clr_s  = (t == 13);
            clr_m  = (t == 15);
            tick(1);
        end

        // 6: reset asserted mid-check with counter at 2
        tname = "t6_midrst";
        do_reset(1'b0);
        tick(3);
        base = cyc;
        push(0, 4, 1'b0, 1'b0, 1);
        push(0, 5, 1'b0, 1'b1, 1);
        push(0, 6, 1'b0, 1'b0, 0);
        push(1, 6, 1'b0, 1'b0, 0);
        push(2, 6, 1'b0, 1'b0, 0);
        for (int t = 0; t < 6; t++) begin
            signal = (t != 1);
            tick(1);
        end
        #1;
        rst_n = 1'b0;
        tick(3);
        base  = cyc;
        rst_n = 1'b1;
        push(0, 5, 1'b0, 1'b1, 0);
        push(0, 6, 1'b1, 1'b0, 0);
        tick(8);

        // Settled state after the mid-check reset with the input held high
        n_vec++;
        if (clean_m !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_settle.main.clean: got %b, expected 1", clean_m);
        end
        n_vec++;
        if (busy_m !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_settle.main.busy: got %b, expected 0", busy_m);
        end
        n_vec++;
        if (gc_m !== 8'd0) begin
            n_fail++;
            $display("FAIL t6_settle.main.glitch: got %0d, expected 0", gc_m);
        end
        n_vec++;
        if (clean_s !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_settle.sat.clean: got %b, expected 1", clean_s);
        end
        n_vec++;
        if (gc_s !== 2'd0) begin
            n_fail++;
            $display("FAIL t6_settle.sat.glitch: got %0d, expected 0", gc_s);
        end
        n_vec++;
        if (clean_d !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_settle.d1.clean: got %b, expected 1", clean_d);
        end
        n_vec++;
        if (busy_d !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_settle.d1.busy: got %b, expected 0", busy_d);
        end

        // Drain anything still pending, bounded
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick(1);
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            n_vec++;
            n_fail++;
            $display("FAIL %s: never checked, due cycle %0d, now cycle %0d", mon_n, mon_e.cyc, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
